// File: rtl/mips_prog_loader_pkg.sv
// Shared loader definitions: FSM state encoding and word geometry, common to the
// loader and the core's memory-port code.
package mips_prog_loader_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_HDR,
      ST_DATA,
      ST_DONE,
      ST_ERR
   } ld_state_e;

   localparam int unsigned BYTES_PER_WORD = 4;
   localparam int unsigned LANE_W         = $clog2(BYTES_PER_WORD);

   // States in which the loader consumes host bytes
   function automatic logic is_stream_state(input ld_state_e s);
      return (s == ST_HDR) || (s == ST_DATA);
   endfunction

endpackage

// File: rtl/mips_prog_loader_if.sv
// Host byte-stream channel into the program loader (valid/ready handshake).
interface mips_prog_loader_if;

   logic       in_valid;
   logic       in_ready;
   logic [7:0] in_byte;
   logic       in_last;

   modport master (
      output in_valid,
      output in_byte,
      output in_last,
      input  in_ready
   );

   modport slave (
      input  in_valid,
      input  in_byte,
      input  in_last,
      output in_ready
   );

endinterface

// File: rtl/mips_byte_packer.sv
// Big-endian byte-to-word packer: 2-bit lane counter plus shift register of the
// bytes already received; word_o presents the completed word on the 4th byte.
module mips_byte_packer
   import mips_prog_loader_pkg::*;
(
   input  logic        clk1,
   input  logic        reset,
   input  logic        accept_i,
   input  logic [7:0]  byte_i,
   input  logic        clear_i,
   output logic        word_done_o,
   output logic [31:0] word_o
);

   logic [LANE_W-1:0] lane_q, lane_d;
   logic [23:0]       shreg_q, shreg_d;

   always_comb begin
      lane_d  = lane_q;
      shreg_d = shreg_q;
      if (clear_i) begin
         lane_d  = '0;
         shreg_d = '0;
      end else if (accept_i) begin
         lane_d  = lane_q + 1'b1;
         shreg_d = {shreg_q[15:0], byte_i};
      end
   end

   always_ff @(posedge clk1) begin
      if (reset) begin
         lane_q  <= '0;
         shreg_q <= '0;
      end else begin
         lane_q  <= lane_d;
         shreg_q <= shreg_d;
      end
   end

   // Only the three earlier bytes are stored; the 4th is taken straight from the bus
   assign word_done_o = accept_i && !clear_i && (lane_q == LANE_W'(BYTES_PER_WORD - 1));
   assign word_o      = {shreg_q, byte_i};

endmodule

// File: rtl/mips_prog_loader.sv
// Program loader for pipe_MIPS32: parses a 4-byte base-address header, writes the
// following big-endian words to memory, and releases the core with an initial PC.
module mips_prog_loader
   import mips_prog_loader_pkg::*;
#(
   parameter int unsigned ADDR_W = 10
) (
   input  logic                clk1,
   input  logic                reset,
   input  logic                start,
   mips_prog_loader_if.slave   in_if,
   output logic                mem_we,
   output logic [ADDR_W-1:0]   mem_addr,
   output logic [31:0]         mem_wdata,
   output logic                cpu_hold,
   output logic [31:0]         pc_init,
   output logic                done,
   output logic                error,
   output logic [ADDR_W:0]     word_cnt
);

   localparam logic [31:0] HDR_HI_MASK = ~((32'd1 << ADDR_W) - 32'd1);

   ld_state_e         state_q, state_d;
   logic [ADDR_W-1:0] base_q, base_d;
   logic [ADDR_W:0]   cnt_q, cnt_d;
   logic              we_q, we_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [31:0]       wdata_q, wdata_d;
   logic              hold_q, hold_d;
   logic [31:0]       pc_q, pc_d;
   logic              done_q, done_d;
   logic              err_q, err_d;
   logic              rdy_q, rdy_d;

   logic              accept;
   logic              pk_clear;
   logic              pk_done;
   logic [31:0]       pk_word;
   logic [ADDR_W+1:0] wr_addr;
   logic              wr_ovf;
   logic              hdr_bad;

   assign accept  = in_if.in_valid && rdy_q;
   assign wr_addr = {2'b00, base_q} + {1'b0, cnt_q};
   assign wr_ovf  = |wr_addr[ADDR_W+1:ADDR_W];
   assign hdr_bad = |(pk_word & HDR_HI_MASK);

   mips_byte_packer u_packer (
      .clk1        (clk1),
      .reset       (reset),
      .accept_i    (accept),
      .byte_i      (in_if.in_byte),
      .clear_i     (pk_clear),
      .word_done_o (pk_done),
      .word_o      (pk_word)
   );

   always_comb begin
      state_d  = state_q;
      base_d   = base_q;
      cnt_d    = cnt_q;
      we_d     = 1'b0;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      hold_d   = hold_q;
      pc_d     = pc_q;
      done_d   = done_q;
      err_d    = err_q;
      pk_clear = 1'b0;

      unique case (state_q)
         ST_IDLE, ST_DONE, ST_ERR: begin
            if (start) begin
               state_d  = ST_HDR;
               cnt_d    = '0;
               done_d   = 1'b0;
               err_d    = 1'b0;
               hold_d   = 1'b1;
               pk_clear = 1'b1;
            end else if (state_q == ST_DONE) begin
               // done/release lag entry by one cycle so the final write lands first
               done_d = 1'b1;
               hold_d = 1'b0;
               pc_d   = 32'(base_q);
            end
         end
         ST_HDR: begin
            if (accept) begin
               if (in_if.in_last) begin
                  state_d = ST_ERR;
                  err_d   = 1'b1;
               end else if (pk_done) begin
                  if (hdr_bad) begin
                     state_d = ST_ERR;
                     err_d   = 1'b1;
                  end else begin
                     state_d = ST_DATA;
                     base_d  = pk_word[ADDR_W-1:0];
                  end
               end
            end
         end
         ST_DATA: begin
            if (accept) begin
               if (pk_done) begin
                  if (wr_ovf) begin
                     state_d = ST_ERR;
                     err_d   = 1'b1;
                  end else begin
                     we_d    = 1'b1;
                     addr_d  = wr_addr[ADDR_W-1:0];
                     wdata_d = pk_word;
                     cnt_d   = cnt_q + 1'b1;
                     if (in_if.in_last) state_d = ST_DONE;
                  end
               end else if (in_if.in_last) begin
                  state_d = ST_ERR;
                  err_d   = 1'b1;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase

      rdy_d = is_stream_state(state_d);
   end

   always_ff @(posedge clk1) begin
      if (reset) begin
         state_q <= ST_IDLE;
         base_q  <= '0;
         cnt_q   <= '0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         hold_q  <= 1'b1;
         pc_q    <= '0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
         rdy_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         base_q  <= base_d;
         cnt_q   <= cnt_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         hold_q  <= hold_d;
         pc_q    <= pc_d;
         done_q  <= done_d;
         err_q   <= err_d;
         rdy_q   <= rdy_d;
      end
   end

   assign in_if.in_ready = rdy_q;
   assign mem_we         = we_q;
   assign mem_addr       = addr_q;
   assign mem_wdata      = wdata_q;
   assign cpu_hold       = hold_q;
   assign pc_init        = pc_q;
   assign done           = done_q;
   assign error          = err_q;
   assign word_cnt       = cnt_q;

endmodule

// File: tb/tb_mips_prog_loader.sv
// Directed bench for mips_prog_loader: a 10-bit-address loader for normal, gapped,
// truncated and reset scenarios, and a 4-bit-address loader for overflow/header faults.
module tb_mips_prog_loader;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       start_a = 1'b0;
   logic       start_b = 1'b0;
   logic       valid = 1'b0;
   logic       last = 1'b0;
   logic [7:0] byt = '0;
   logic       sel = 1'b0;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   mips_prog_loader_if ifa ();
   mips_prog_loader_if ifb ();

   assign ifa.in_valid = valid & ~sel;
   assign ifa.in_byte  = byt;
   assign ifa.in_last  = last;
   assign ifb.in_valid = valid & sel;
   assign ifb.in_byte  = byt;
   assign ifb.in_last  = last;

   logic cur_rdy;
   assign cur_rdy = sel ? ifb.in_ready : ifa.in_ready;

   logic        a_we, a_hold, a_done, a_err;
   logic [9:0]  a_addr;
   logic [31:0] a_wdata, a_pc;
   logic [10:0] a_cnt;

   logic        b_we, b_hold, b_done, b_err;
   logic [3:0]  b_addr;
   logic [31:0] b_wdata, b_pc;
   logic [4:0]  b_cnt;

   mips_prog_loader #(.ADDR_W(10)) dut_a (
      .clk1(clk), .reset(reset), .start(start_a), .in_if(ifa),
      .mem_we(a_we), .mem_addr(a_addr), .mem_wdata(a_wdata), .cpu_hold(a_hold),
      .pc_init(a_pc), .done(a_done), .error(a_err), .word_cnt(a_cnt)
   );

   mips_prog_loader #(.ADDR_W(4)) dut_b (
      .clk1(clk), .reset(reset), .start(start_b), .in_if(ifb),
      .mem_we(b_we), .mem_addr(b_addr), .mem_wdata(b_wdata), .cpu_hold(b_hold),
      .pc_init(b_pc), .done(b_done), .error(b_err), .word_cnt(b_cnt)
   );

   logic [31:0] mema [0:1023];
   logic [31:0] memb [0:15];
   int we_a = 0;
   int we_b = 0;

   always @(posedge clk) begin
      if (a_we) begin
         mema[a_addr] <= a_wdata;
         we_a <= we_a + 1;
      end
      if (b_we) begin
         memb[b_addr] <= b_wdata;
         we_b <= we_b + 1;
      end
   end

   logic [31:0] prog [9] = '{32'h2801000a, 32'h28020014, 32'h28030019, 32'h0ce77800,
                             32'h0ce77800, 32'h00222000, 32'h0ce77800, 32'h00832800,
                             32'hfc000000};

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send_byte(input logic [7:0] b, input logic l);
      int unsigned n = 0;
      byt   = b;
      last  = l;
      valid = 1'b1;
      while (!cur_rdy && n < 20) begin
         step();
         n++;
      end
      chk("ready_wait", 64'(n < 20), 64'd1);
      step();
      valid = 1'b0;
      last  = 1'b0;
   endtask

   task automatic send_word(input logic [31:0] w, input logic l, input int unsigned maxgap);
      for (int i = 0; i < 4; i++) begin
         if (maxgap > 0) repeat ($urandom_range(0, maxgap)) step();
         send_byte(w[31 - 8*i -: 8], l && (i == 3));
      end
   endtask

   task automatic pulse_a();
      start_a = 1'b1;
      step();
      start_a = 1'b0;
   endtask

   task automatic pulse_b();
      start_b = 1'b1;
      step();
      start_b = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (3) step();
      reset = 1'b0;
      chk("rst_ready",  64'(ifa.in_ready), 64'd0);
      chk("rst_hold",   64'(a_hold), 64'd1);
      chk("rst_we",     64'(a_we), 64'd0);
      chk("rst_addr",   64'(a_addr), 64'd0);
      chk("rst_wdata",  64'(a_wdata), 64'd0);
      chk("rst_pc",     64'(a_pc), 64'd0);
      chk("rst_done",   64'(a_done), 64'd0);
      chk("rst_err",    64'(a_err), 64'd0);
      chk("rst_cnt",    64'(a_cnt), 64'd0);
      chk("rst_b_hold", 64'(b_hold), 64'd1);

      // Basic 9-word load at base 0
      sel = 1'b0;
      pulse_a();
      chk("t1_ready", 64'(ifa.in_ready), 64'd1);
      chk("t1_hold",  64'(a_hold), 64'd1);
      send_word(32'h0, 1'b0, 0);
      chk("t1_hdr_nowe", 64'(we_a), 64'd0);
      for (int k = 0; k < 9; k++) send_word(prog[k], k == 8, 0);
      chk("t1_last_we",    64'(a_we), 64'd1);
      chk("t1_last_addr",  64'(a_addr), 64'd8);
      chk("t1_last_wdata", 64'(a_wdata), 64'hfc000000);
      chk("t1_done_early", 64'(a_done), 64'd0);
      step();
      chk("t1_done",  64'(a_done), 64'd1);
      chk("t1_hold0", 64'(a_hold), 64'd0);
      chk("t1_cnt",   64'(a_cnt), 64'd9);
      chk("t1_pc",    64'(a_pc), 64'd0);
      chk("t1_rdy0",  64'(ifa.in_ready), 64'd0);
      chk("t1_nwe",   64'(we_a), 64'd9);
      for (int k = 0; k < 9; k++) chk("t1_mem", 64'(mema[k]), 64'(prog[k]));

      // Base 0x10 with random gaps; start mid-DATA must be ignored
      pulse_a();
      chk("t2_done_clr", 64'(a_done), 64'd0);
      chk("t2_hold",     64'(a_hold), 64'd1);
      chk("t2_cnt0",     64'(a_cnt), 64'd0);
      send_word(32'h10, 1'b0, 3);
      for (int k = 0; k < 9; k++) begin
         send_word(prog[k], k == 8, 3);
         if (k == 3) begin
            pulse_a();
            chk("t2_ign_rdy", 64'(ifa.in_ready), 64'd1);
            chk("t2_ign_cnt", 64'(a_cnt), 64'd4);
         end
      end
      step();
      chk("t2_done", 64'(a_done), 64'd1);
      chk("t2_cnt",  64'(a_cnt), 64'd9);
      chk("t2_pc",   64'(a_pc), 64'h10);
      chk("t2_nwe",  64'(we_a), 64'd18);
      for (int k = 0; k < 9; k++) chk("t2_mem", 64'(mema[16 + k]), 64'(prog[k]));

      // in_last on byte 1 of word 3 aborts; restart loads cleanly
      pulse_a();
      send_word(32'h20, 1'b0, 0);
      send_word(prog[0], 1'b0, 0);
      send_word(prog[1], 1'b0, 0);
      send_byte(8'h28, 1'b0);
      send_byte(8'h03, 1'b1);
      chk("t3_err",  64'(a_err), 64'd1);
      chk("t3_rdy",  64'(ifa.in_ready), 64'd0);
      chk("t3_hold", 64'(a_hold), 64'd1);
      chk("t3_we",   64'(a_we), 64'd0);
      chk("t3_cnt",  64'(a_cnt), 64'd2);
      step();
      chk("t3_nwe",  64'(we_a), 64'd20);
      chk("t3_mem0", 64'(mema[32]), 64'(prog[0]));
      chk("t3_mem1", 64'(mema[33]), 64'(prog[1]));
      pulse_a();
      chk("t3_err_clr", 64'(a_err), 64'd0);
      chk("t3_rdy1",    64'(ifa.in_ready), 64'd1);
      send_word(32'h30, 1'b0, 0);
      send_word(32'h12345678, 1'b1, 0);
      step();
      chk("t3_done", 64'(a_done), 64'd1);
      chk("t3_cnt1", 64'(a_cnt), 64'd1);
      chk("t3_pc",   64'(a_pc), 64'h30);
      chk("t3_mem",  64'(mema[48]), 64'h12345678);

      // ADDR_W=4: second word past address 15 overflows; header top byte faults
      sel = 1'b1;
      pulse_b();
      send_word(32'h0000000f, 1'b0, 0);
      send_word(32'h11223344, 1'b0, 0);
      chk("t4_we",    64'(b_we), 64'd1);
      chk("t4_addr",  64'(b_addr), 64'd15);
      chk("t4_wdata", 64'(b_wdata), 64'h11223344);
      send_word(32'haabbccdd, 1'b1, 0);
      chk("t4_ovf_err",  64'(b_err), 64'd1);
      chk("t4_ovf_we",   64'(b_we), 64'd0);
      chk("t4_ovf_cnt",  64'(b_cnt), 64'd1);
      chk("t4_ovf_hold", 64'(b_hold), 64'd1);
      step();
      chk("t4_nwe", 64'(we_b), 64'd1);
      chk("t4_mem", 64'(memb[15]), 64'h11223344);
      pulse_b();
      chk("t4_err_clr", 64'(b_err), 64'd0);
      send_word(32'h01000000, 1'b0, 0);
      chk("t4_hdr_err", 64'(b_err), 64'd1);
      chk("t4_hdr_rdy", 64'(ifb.in_ready), 64'd0);
      chk("t4_hdr_nwe", 64'(we_b), 64'd1);

      // Reset after 6 data bytes
      sel = 1'b0;
      pulse_a();
      send_word(32'h40, 1'b0, 0);
      send_word(32'hdeadbeef, 1'b0, 0);
      send_byte(8'h01, 1'b0);
      send_byte(8'h02, 1'b0);
      reset = 1'b1;
      step();
      chk("t5_rdy",   64'(ifa.in_ready), 64'd0);
      chk("t5_hold",  64'(a_hold), 64'd1);
      chk("t5_cnt",   64'(a_cnt), 64'd0);
      chk("t5_we",    64'(a_we), 64'd0);
      chk("t5_addr",  64'(a_addr), 64'd0);
      chk("t5_wdata", 64'(a_wdata), 64'd0);
      chk("t5_done",  64'(a_done), 64'd0);
      chk("t5_err",   64'(a_err), 64'd0);
      chk("t5_pc",    64'(a_pc), 64'd0);
      chk("t5_mem",   64'(mema[64]), 64'hdeadbeef);
      reset = 1'b0;
      repeat (2) step();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
